pll_reconf_loader: RTL

- Sequencer on the reading side of the PLL reconfiguration ROM.
- On a mode-change request from the ROM (trigger_read), it does the following in order:
  - walks the ROM address space;
  - captures the serial configuration bits returned on q;
  - shifts them into the PLL scan chain;
  - waits for the ROM's reconfig strobe;
  - issues configupdate;
  - monitors scandone until the PLL has re-locked its new configuration.
- Its busy output drives the ROM's pll_reconf_busy input, closing the request loop.

---
 rtl/pll_reconf_loader.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/pll_reconf_loader.sv
// rtl/pll_reconf_loader.sv - PLL reconfiguration ROM reader and scan-chain loader
// Walks the ROM, shifts its bits into the PLL scan chain, then issues configupdate and waits for scandone.
module pll_reconf_loader #(
  parameter int SCAN_LEN       = 144,
  parameter int ROM_LATENCY    = 2,
  parameter int STROBE_TIMEOUT = 16,
  parameter int DONE_TIMEOUT   = 1024
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       trigger_read,
  output logic [7:0] address,
  output logic       read_ena,
  input  logic       q,
  input  logic       reconfig,
  output logic       scandata,
  output logic       scanclkena,
  output logic       configupdate,
  input  logic       scandone,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int TMAX = (DONE_TIMEOUT > STROBE_TIMEOUT) ? DONE_TIMEOUT : STROBE_TIMEOUT;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [8:0]    LAST_ADDR   = 9'(SCAN_LEN - 1);
  localparam logic [8:0]    FULL_COUNT  = 9'(SCAN_LEN);
  localparam logic [TW-1:0] STROBE_LAST = TW'(STROBE_TIMEOUT - 1);
  localparam logic [TW-1:0] DONE_LAST   = TW'(DONE_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_UPDATE,
    S_WAIT_HI,
    S_WAIT_LO
  } state_t;

  state_t                 state_q, state_d;
  logic [8:0]             rd_cnt_q, rd_cnt_d;
  logic                   read_ena_q, read_ena_d;
  logic [ROM_LATENCY-1:0] en_pipe_q, en_pipe_d;
  logic                   scandata_q, scandata_d;
  logic                   scanclkena_q, scanclkena_d;
  logic [8:0]             cap_cnt_q, cap_cnt_d;
  logic                   strobe_seen_q, strobe_seen_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic                   configupdate_q, configupdate_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   error_q, error_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= S_IDLE;
      rd_cnt_q       <= '0;
      read_ena_q     <= 1'b0;
      en_pipe_q      <= '0;
      scandata_q     <= 1'b0;
      scanclkena_q   <= 1'b0;
      cap_cnt_q      <= '0;
      strobe_seen_q  <= 1'b0;
      timer_q        <= '0;
      configupdate_q <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      rd_cnt_q       <= rd_cnt_d;
      read_ena_q     <= read_ena_d;
      en_pipe_q      <= en_pipe_d;
      scandata_q     <= scandata_d;
      scanclkena_q   <= scanclkena_d;
      cap_cnt_q      <= cap_cnt_d;
      strobe_seen_q  <= strobe_seen_d;
      timer_q        <= timer_d;
      configupdate_q <= configupdate_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      error_q        <= error_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    rd_cnt_d       = rd_cnt_q;
    read_ena_d     = read_ena_q;
    scandata_d     = scandata_q;
    scanclkena_d   = 1'b0;
    cap_cnt_d      = cap_cnt_q;
    strobe_seen_d  = strobe_seen_q;
    configupdate_d = 1'b0;
    busy_d         = busy_q;
    done_d         = 1'b0;
    error_d        = error_q;

    // The delayed enable marks the cycle in which q carries the bit for an issued address.
    en_pipe_d = ROM_LATENCY'({en_pipe_q, read_ena_q});
    if (en_pipe_q[ROM_LATENCY-1]) begin
      scandata_d   = q;
      scanclkena_d = 1'b1;
      cap_cnt_d    = cap_cnt_q + 9'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (trigger_read) begin
          state_d       = S_READ;
          rd_cnt_d      = '0;
          read_ena_d    = 1'b1;
          busy_d        = 1'b1;
          error_d       = 1'b0;
          cap_cnt_d     = '0;
          strobe_seen_d = 1'b0;
        end
      end
      S_READ: begin
        if (reconfig) strobe_seen_d = 1'b1;
        if (rd_cnt_q == LAST_ADDR) begin
          read_ena_d = 1'b0;
          state_d    = S_DRAIN;
        end else begin
          rd_cnt_d = rd_cnt_q + 9'd1;
        end
      end
      S_DRAIN: begin
        if (reconfig) strobe_seen_d = 1'b1;
        if (cap_cnt_q == FULL_COUNT && (strobe_seen_q || reconfig)) begin
          state_d        = S_UPDATE;
          configupdate_d = 1'b1;
        end else if (timer_q == STROBE_LAST) begin
          state_d = S_IDLE;
          error_d = 1'b1;
          busy_d  = 1'b0;
        end
      end
      S_UPDATE: begin
        state_d = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        if (scandone) begin
          state_d = S_WAIT_LO;
        end else if (timer_q == DONE_LAST) begin
          state_d = S_IDLE;
          error_d = 1'b1;
          busy_d  = 1'b0;
        end
      end
      S_WAIT_LO: begin
        if (!scandone) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else if (timer_q == DONE_LAST) begin
          state_d = S_IDLE;
          error_d = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d    = S_IDLE;
        read_ena_d = 1'b0;
        busy_d     = 1'b0;
      end
    endcase

    // Every state entry restarts the timeout count.
    if (state_d != state_q || state_q == S_IDLE) timer_d = '0;
    else                                        timer_d = timer_q + TW'(1);
  end

  assign address      = rd_cnt_q[7:0];
  assign read_ena     = read_ena_q;
  assign scandata     = scandata_q;
  assign scanclkena   = scanclkena_q;
  assign configupdate = configupdate_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;

endmodule
